// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: sequences IRAM reads, captures the returned word
// and offers it to decode over valid/ready, with redirect and HALT handling.
module ifetch_ctrl #(
    parameter int                    ADDR_W      = 24,
    parameter int                    INS_W       = 24,
    parameter logic [ADDR_W-1:0]     RESET_PC    = '0,
    parameter int                    OPCODE_W    = 8,
    parameter logic [OPCODE_W-1:0]   HALT_OPCODE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              iram_read,
    output logic [ADDR_W-1:0] iram_addr,
    input  logic [INS_W-1:0]  iram_ins,
    output logic [INS_W-1:0]  ins_out,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [INS_W-1:0]    ins_reg, ins_next;
    logic [ADDR_W-1:0]   pc_out_reg, pc_out_next;
    logic                is_halt_op;

    assign is_halt_op = (ins_reg[INS_W-1 -: OPCODE_W] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            fetch_pc_reg <= RESET_PC;
            ins_reg      <= '0;
            pc_out_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            ins_reg      <= ins_next;
            pc_out_reg   <= pc_out_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        ins_next      = ins_reg;
        pc_out_next   = pc_out_reg;
        // A redirect restarts fetching from every state and beats any handshake.
        if (redirect) begin
            fetch_pc_next = redirect_pc;
            state_next    = S_REQ;
        end else begin
            case (state_reg)
                S_IDLE: if (start) state_next = S_REQ;
                S_REQ:  state_next = S_WAIT;
                S_WAIT: begin
                    ins_next    = iram_ins;
                    pc_out_next = fetch_pc_reg;
                    state_next  = S_HOLD;
                end
                S_HOLD: begin
                    if (ins_ready) begin
                        if (is_halt_op) begin
                            state_next = S_HALT;
                        end else begin
                            fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
                            state_next    = S_REQ;
                        end
                    end
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign iram_read = (state_reg == S_REQ);
    assign iram_addr = fetch_pc_reg;
    assign ins_valid = (state_reg == S_HOLD);
    assign halted    = (state_reg == S_HALT);
    assign ins_out   = ins_reg;
    assign pc_out    = pc_out_reg;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: IRAM model, transaction-level reference model checked
// every cycle, plus directed literal checks from the fetch scenarios.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        iram_read;
    logic [23:0] iram_addr;
    logic [23:0] iram_ins = 24'hBAD0BA;
    logic [23:0] ins_out;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [23:0] pc_out;
    logic        redirect = 1'b0;
    logic [23:0] redirect_pc = '0;
    logic        halted;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    ifetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .iram_read(iram_read), .iram_addr(iram_addr), .iram_ins(iram_ins),
        .ins_out(ins_out), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .pc_out(pc_out), .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // IRAM contents; opcode never 8'hFF except the planted HALT word.
    function automatic logic [23:0] mem_word(input logic [23:0] a);
        if (a == 24'h000000) return 24'h010203;
        if (a == 24'h000005) return 24'hFF0000;
        return {1'b0, a[6:0], a[15:0] ^ 16'h1234};
    endfunction

    // IRAM: data follows a read by one cycle; garbage otherwise.
    always @(posedge clk)
        iram_ins <= iram_read ? mem_word(iram_addr) : 24'hBAD0BA;

    // Reference model: read-issue age, shown instruction, halt flag.
    logic [23:0] m_pc = '0, m_ins = '0, m_pcout = '0;
    bit          m_show = 1'b0, m_halt = 1'b0;
    int          m_age = -1;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = '0; m_ins = '0; m_pcout = '0;
            m_show = 1'b0; m_halt = 1'b0; m_age = -1;
        end else if (redirect) begin
            m_pc = redirect_pc; m_age = 0; m_show = 1'b0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_age = -1;
        end else if (m_show) begin
            if (ins_ready) begin
                m_show = 1'b0;
                if (m_ins[23:16] == 8'hFF) m_halt = 1'b1;
                else begin m_pc = m_pc + 24'd1; m_age = 0; end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (m_age == 1) begin
            m_ins = mem_word(m_pc); m_pcout = m_pc; m_show = 1'b1; m_age = -1;
        end else if (start) begin
            m_age = 0;
        end
    end

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model", {iram_read, iram_addr, ins_valid, ins_out, pc_out, halted},
                {m_age == 0, m_pc, m_show, m_ins, m_pcout, m_halt});
            $display("cycle t=%0t read=%b addr=%h valid=%b ins=%h pc=%h halted=%b",
                     $time, iram_read, iram_addr, ins_valid, ins_out, pc_out, halted);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step();
        check_en = 1'b1;
        step();
        chk("reset_vals", {iram_read, iram_addr, ins_valid, ins_out, pc_out, halted}, '0);
        rst = 1'b0;

        // Start latency and first fetch
        start = 1'b1; ins_ready = 1'b1;
        step(); start = 1'b0;
        chk("t1_read_c1", {iram_read, iram_addr}, {1'b1, 24'h000000});
        step();
        chk("t1_wait_c2", {iram_read, ins_valid}, 2'b00);
        ins_ready = 1'b0;
        step();
        chk("t1_valid_c3", {ins_valid, ins_out, pc_out}, {1'b1, 24'h010203, 24'h000000});
        ins_ready = 1'b1;
        step();
        chk("t1_next_c4", {iram_read, iram_addr}, {1'b1, 24'h000001});

        // Backpressure on address 1
        ins_ready = 1'b0;
        step(); step();
        chk("t2_hold_valid", {ins_valid, pc_out}, {1'b1, 24'h000001});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_stable", {ins_valid, iram_read, ins_out, pc_out},
                {2'b10, mem_word(24'h000001), 24'h000001});
        end
        ins_ready = 1'b1;
        step();
        chk("t2_one_accept", {iram_read, iram_addr, ins_valid}, {1'b1, 24'h000002, 1'b0});

        // Redirect in WAIT, then in HOLD with ready high
        step();
        redirect = 1'b1; redirect_pc = 24'h000040;
        step(); redirect = 1'b0;
        chk("t3_wait_redir", {iram_read, iram_addr, ins_valid}, {1'b1, 24'h000040, 1'b0});
        step(); step();
        chk("t3_hold", {ins_valid, pc_out}, {1'b1, 24'h000040});
        redirect = 1'b1;
        step(); redirect = 1'b0;
        chk("t3_hold_redir", {iram_read, iram_addr, ins_valid}, {1'b1, 24'h000040, 1'b0});

        // HALT opcode at address 5
        redirect = 1'b1; redirect_pc = 24'h000005;
        step(); redirect = 1'b0;
        step(); step();
        chk("t4_halt_ins", {ins_valid, ins_out}, {1'b1, 24'hFF0000});
        step();
        chk("t4_halted", {halted, iram_read, ins_valid}, 3'b100);
        start = 1'b1;
        step(); step(); start = 1'b0;
        chk("t4_start_ign", {halted, iram_read}, 2'b10);
        redirect = 1'b1; redirect_pc = 24'h000010;
        step(); redirect = 1'b0;
        chk("t4_resume", {halted, iram_read, iram_addr}, {2'b01, 24'h000010});

        // PC wrap
        redirect = 1'b1; redirect_pc = 24'hFFFFFF;
        step(); redirect = 1'b0;
        step(); step();
        chk("t5_hold_top", {ins_valid, pc_out}, {1'b1, 24'hFFFFFF});
        step();
        chk("t5_wrap", {iram_read, iram_addr}, {1'b1, 24'h000000});

        // Reset in WAIT and in HOLD
        step();
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("t6_rst_wait", {iram_read, iram_addr, ins_valid, ins_out, pc_out, halted}, '0);
        start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        chk("t6_pre_hold", ins_valid, 1'b1);
        ins_ready = 1'b0;
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("t6_rst_hold", {iram_read, iram_addr, ins_valid, ins_out, pc_out, halted}, '0);

        // Start and redirect together in IDLE: redirect wins
        start = 1'b1; redirect = 1'b1; redirect_pc = 24'h000033;
        step(); start = 1'b0; redirect = 1'b0;
        chk("idle_both", {iram_read, iram_addr}, {1'b1, 24'h000033});
        ins_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
